// File: rtl/rgb_pwm.sv
// rgb_pwm: valid/ready colour input driving PWM status LEDs, new duty applied at period boundaries.
// Define RGB_PWM_FADE_EN to step each duty by one per period toward the latest requested colour.
module rgb_pwm #(
   parameter int DW = 8,
   parameter int PRESCALE = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_r,
   input  logic [DW-1:0] in_g,
   input  logic [DW-1:0] in_b,
   input  logic          en,
   output logic          led_r,
   output logic          led_g,
   output logic          led_b,
   output logic          period_start
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam logic [DW-1:0] PMAX = {{(DW-1){1'b1}}, 1'b0};
   logic [PW-1:0] pre;
   logic [DW-1:0] phase, duty_r, duty_g, duty_b, pend_r, pend_g, pend_b;
   logic tick, boundary, xfer;
   assign tick = pre == PW'(PRESCALE - 1);
   assign boundary = tick && phase == PMAX;
   assign xfer = in_valid && in_ready;
`ifdef RGB_PWM_FADE_EN
   function automatic logic [DW-1:0] fade(input logic [DW-1:0] d, input logic [DW-1:0] t);
      return d < t ? d + 1'b1 : d > t ? d - 1'b1 : d;
   endfunction
   assign in_ready = !rst;
   always_ff @(posedge clk)
      if (rst) begin
         {pend_r, pend_g, pend_b} <= '0;
         {duty_r, duty_g, duty_b} <= '0;
      end else begin
         if (xfer) {pend_r, pend_g, pend_b} <= {in_r, in_g, in_b};
         if (boundary) {duty_r, duty_g, duty_b} <= {fade(duty_r, pend_r), fade(duty_g, pend_g), fade(duty_b, pend_b)};
      end
`else
   logic pending;
   assign in_ready = !pending && !rst;
   // a slot filled on a boundary cycle waits for the following boundary
   always_ff @(posedge clk)
      if (rst) begin
         pending <= 1'b0;
         {pend_r, pend_g, pend_b} <= '0;
         {duty_r, duty_g, duty_b} <= '0;
      end else if (boundary && pending) begin
         {duty_r, duty_g, duty_b} <= {pend_r, pend_g, pend_b};
         pending <= 1'b0;
      end else if (xfer) begin
         {pend_r, pend_g, pend_b} <= {in_r, in_g, in_b};
         pending <= 1'b1;
      end
`endif
   always_ff @(posedge clk)
      if (rst) begin
         pre <= '0;
         phase <= '0;
         {led_r, led_g, led_b} <= 3'b000;
         period_start <= 1'b0;
      end else begin
         pre <= tick ? '0 : pre + 1'b1;
         phase <= tick ? (phase == PMAX ? '0 : phase + 1'b1) : phase;
         led_r <= en && (phase < duty_r);
         led_g <= en && (phase < duty_g);
         led_b <= en && (phase < duty_b);
         period_start <= boundary;
      end
endmodule

// File: doc/rgb_pwm.md
# rgb_pwm

Downstream LED output stage for the RGB status LEDs. It accepts an 8-bit-per-channel colour over a valid/ready handshake and drives `led_r`/`led_g`/`led_b` with a free-running PWM. New colours take effect only at a PWM period boundary, so the LEDs never show glitched partial periods. It replaces raw counter bits on the LED pins with controllable brightness.

## Interface
- `DW`, 8: duty/phase width in bits. One PWM period is 2^DW−1 ticks.
- `PRESCALE`, 16: clock cycles per PWM tick; legal values ≥1.
- `clk` input 1: single clock.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: colour word on `in_r/in_g/in_b` is valid.
- `in_ready` output 1: block can accept a colour word this cycle.
- `in_r`, `in_g`, `in_b` input DW each: requested duty per channel; 0 = off, 2^DW−1 = fully on.
- `en` input 1: output enable; low forces all LEDs off.
- `led_r`, `led_g`, `led_b` output 1: registered PWM outputs, active-high.
- `period_start` output 1: one-cycle pulse on the first cycle of each PWM period.

## Operation
- Prescaler `pre` counts 0..PRESCALE−1 and wraps. `tick` is asserted when `pre == PRESCALE−1`.
- Phase counter `phase` (DW bits) advances on `tick`, counting 0..2^DW−2 and then wrapping to 0.
  - A boundary is a `tick` with `phase == 2^DW−2`.
- Active duty registers `duty_r/g/b` hold the values in effect.
  - Each LED is computed as `led_x <= en && (phase < duty_x)`.
  - duty 0 gives constant off. duty 2^DW−1 gives constant on.
- Handshake, single pending slot:
  - `in_ready = !pending && !rst`.
  - A transfer occurs when `in_valid && in_ready`. It loads the pending registers and sets `pending`.
  - At a boundary, if `pending` is set: `duty_x <= pending_x` and `pending` clears.
  - A transfer on a boundary cycle fills the slot only. It is applied at the next boundary.
  - A second word stalls with `in_ready` low until the boundary frees the slot.
- `en` does not affect the counters, the handshake or `period_start`.
- Reset (synchronous, mid-operation included) clears on the next edge:
  - `pre`, `phase`, `duty_*` and `pending` go to 0.
  - Pending data is discarded.
  - `led_*` and `period_start` go to 0.
  - `in_ready` is 0 while `rst` is high and 1 in the first cycle after.

## Timing
- LED outputs are registered: 1 cycle from `phase`/`duty`/`en` change to pin.
- `period_start` is registered. It is high in the first cycle where `phase == 0` after a wrap. It is not asserted for the post-reset phase 0.
- Period length is PRESCALE·(2^DW−1) cycles. Accepted-colour-to-effect latency is up to one period plus 1 cycle.
- After `rst` deasserts, the first `period_start` occurs PRESCALE·(2^DW−1) cycles later.
- `en` falling: all LEDs are 0 on the next cycle. `en` rising resumes mid-period at the current phase.

## Configuration
- `RGB_PWM_FADE_EN` defined:
  - Pending registers become target registers.
  - `in_ready = !rst` always, and a transfer overwrites the targets immediately.
  - At each boundary, each `duty_x` steps by +1 or −1 toward `target_x` and holds when equal.
  - A full 0→255 fade therefore takes 255 periods.
- Macro undefined: the single-slot, apply-at-boundary behaviour above. No fade logic is present.

## Test plan
- Reset with DW=8, PRESCALE=1: hold `rst` 2 cycles.
  - All LEDs and `period_start` stay 0.
  - `in_ready` is 0 during reset and 1 in the cycle after.
  - First `period_start` comes 255 cycles after deassert.
- Colour load, DW=8, PRESCALE=1, `en`=1: send r=0, g=128, b=255.
  - After the next boundary, `led_r` is 0 for all 255 cycles, `led_g` is high 128 of 255, `led_b` is high all 255, on every following period.
- Backpressure: `in_valid` held for two words A and B.
  - A is accepted and `in_ready` drops.
  - B stalls until the boundary cycle. B is accepted the cycle after, and A is active for the next period.
- Enable: `en` dropped mid-period with g=128.
  - `led_g` is 0 from the next cycle.
  - The `period_start` cadence is unchanged.
  - On `en` rising, LEDs follow `phase < duty` again.
- Prescale, PRESCALE=4, duty r=64: `led_r` is high 256 of 1020 cycles per period. Reset asserted mid-period then clears all outputs on the next edge.
- Fade, with `RGB_PWM_FADE_EN` defined: from duty 0, target r=3.
  - `duty_r` reads 1, 2, 3 in the next three periods.
  - Retargeting to 1 then gives 2, 1.
